ex_mdu: RTL and testbench

//  Iterative RV32M multiply/divide unit that sits beside the single-cycle execute stage.
//  ex raises start_i for opcode INST_TYPE_R_M with funct7 == 7'b0000001.
//  The unit holds the pipeline through ctrl (hold_flag_o) while it computes.
//  It then writes rd back through the same regs write port that ex drives (rd_addr/rd_data/rd_wen).

---
 rtl/ex_mdu_pkg.sv | 23 ++
 rtl/ex_mdu_div_step.sv | 23 ++
 rtl/ex_mdu.sv | 177 +++++++++++++++++
 tb/tb_ex_mdu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// funct3 op codes, the M-extension funct7 and the MDU state encoding.
package ex_mdu_pkg;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic [6:0] INST_FUNCT7_M = 7'b0000001;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/ex_mdu_div_step.sv
// One restoring-division step on unsigned magnitudes.
// Shifts the next dividend bit into the partial remainder.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_n,
  output logic [XLEN-1:0] quo_n
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;
  logic          ge;

  assign trial = {rem, quo[XLEN-1]};
  assign diff  = trial - {1'b0, dvs};
  assign ge    = ~diff[XLEN];
  assign rem_n = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_n = {quo[XLEN-2:0], ge};

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit beside the execute stage.
// EX_MDU_FASTMUL_EN: single-cycle multiplier for MUL* instead of shift-add.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            hold_flag_o,
  output logic            busy_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state, state_n;

  logic [2:0]        funct3_q;
  logic [4:0]        rd_addr_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic [XLEN-1:0]   rd_data_q;

  logic            accept;
  logic            is_div;
  logic            sgn1, sgn2;
  logic [XLEN-1:0] mag1, mag2;
  logic            neg_in;
  logic            div0, ovf;
  logic [XLEN-1:0] spec_data;
  logic            last;

  assign accept = (state == MDU_IDLE) & start_i & ~flush_i;
  assign is_div = funct3_i[2];

  assign sgn1 = op1_i[XLEN-1] &
    (funct3_i inside {INST_MULH, INST_MULHSU, INST_DIV, INST_REM});
  assign sgn2 = op2_i[XLEN-1] &
    (funct3_i inside {INST_MULH, INST_DIV, INST_REM});
  assign mag1 = sgn1 ? -op1_i : op1_i;
  assign mag2 = sgn2 ? -op2_i : op2_i;

  // Remainder follows the dividend; everything else follows the sign xor.
  assign neg_in = (is_div & funct3_i[1]) ? sgn1 : (sgn1 ^ sgn2);

  assign div0 = is_div & (op2_i == '0);
  assign ovf  = is_div & ~funct3_i[0] &
                (op1_i == MIN_NEG) & (op2_i == '1);
  assign spec_data = div0 ? (funct3_i[1] ? op1_i : '1)
                          : (funct3_i[1] ? '0 : op1_i);

`ifdef EX_MDU_FASTMUL_EN
  assign last = ~funct3_q[2] | (cnt == '0);
`else
  assign last = (cnt == '0);
`endif

  logic [XLEN-1:0] rem_n, quo_n;

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem   (acc[2*XLEN-1:XLEN]),
    .quo   (acc[XLEN-1:0]),
    .dvs   (opb),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );

`ifndef EX_MDU_FASTMUL_EN
  logic [XLEN:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} +
                   ({1'b0, opb} & {(XLEN+1){acc[0]}});
`endif

  logic [2*XLEN-1:0] full;
  logic [XLEN-1:0]   div_raw;
  logic [XLEN-1:0]   div_res;
  logic [XLEN-1:0]   fix_res;

  assign full    = neg_q ? -acc : acc;
  assign div_raw = funct3_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign div_res = neg_q ? -div_raw : div_raw;

  always_comb begin
    fix_res = '0;
    unique case (1'b1)
      funct3_q[2]:
        fix_res = div_res;
      (~funct3_q[2] & (funct3_q[1:0] == 2'b00)):
        fix_res = acc[XLEN-1:0];
      (~funct3_q[2] & (funct3_q[1:0] != 2'b00)):
        fix_res = full[2*XLEN-1:XLEN];
      default:
        fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MDU_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    hold_flag_o = 1'b0;
    unique case (state)
      MDU_IDLE: begin
        if (accept) begin
          hold_flag_o = 1'b1;
          state_n     = (div0 | ovf) ? MDU_DONE : MDU_CALC;
        end
      end
      MDU_CALC: begin
        hold_flag_o = 1'b1;
        if (last) state_n = MDU_FIX;
      end
      MDU_FIX: begin
        hold_flag_o = 1'b1;
        state_n     = MDU_DONE;
      end
      MDU_DONE: state_n = MDU_IDLE;
      default:  state_n = MDU_IDLE;
    endcase
    if (flush_i) state_n = MDU_IDLE;
  end

  assign busy_o    = (state != MDU_IDLE);
  assign rd_wen_o  = (state == MDU_DONE) & ~flush_i;
  assign rd_addr_o = (state == MDU_DONE) ? rd_addr_q : 5'd0;
  assign rd_data_o = rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q  <= '0;
      rd_addr_q <= '0;
      neg_q     <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      opb       <= '0;
      rd_data_q <= '0;
    end else if (accept) begin
      funct3_q  <= funct3_i;
      rd_addr_q <= rd_addr_i;
      neg_q     <= neg_in;
      cnt       <= CNT_W'(XLEN - 1);
      acc       <= {{XLEN{1'b0}}, mag1};
      opb       <= mag2;
      if (div0 | ovf) rd_data_q <= spec_data;
    end else if (state == MDU_CALC && !flush_i) begin
      cnt <= cnt - 1'b1;
      if (funct3_q[2]) begin
        acc <= {rem_n, quo_n};
      end else begin
`ifdef EX_MDU_FASTMUL_EN
        acc <= {{XLEN{1'b0}}, acc[XLEN-1:0]} *
               {{XLEN{1'b0}}, opb};
`else
        acc <= {mul_sum, acc[XLEN-1:1]};
`endif
      end
    end else if (state == MDU_FIX && !flush_i) begin
      rd_data_q <= fix_res;
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboarded bench for ex_mdu: directed RV32M cases plus random ops,
// flush and mid-operation reset, against an arithmetic reference model.
module tb_ex_mdu;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op1_i, op2_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        hold_flag_o, busy_o, rd_wen_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  ex_mdu #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .funct3_i    (funct3_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .rd_addr_i   (rd_addr_i),
    .flush_i     (flush_i),
    .hold_flag_o (hold_flag_o),
    .busy_o      (busy_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .rd_wen_o    (rd_wen_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return 32'(ua / ub);
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if (f3 == 3'd4 || f3 == 3'd6)
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef EX_MDU_FASTMUL_EN
    if (!f3[2]) return 3;
`endif
    return XLEN + 2;
  endfunction

  // Writeback monitor: every strobe must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rd_wen_o) begin
        if (q.size() == 0) begin
          check("unexpected_wb", {27'b0, rd_addr_o, rd_data_o}, 64'h0);
        end else begin
          e = q.pop_front();
          check("wb_data", {32'b0, rd_data_o}, {32'b0, e.data});
          check("wb_addr", {59'b0, rd_addr_o}, {59'b0, e.rd});
          check("wb_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd);
    exp_t e;
    int   lat;
    logic hold_ok;
    @(negedge clk);
    start_i   = 1'b1;
    funct3_i  = f3;
    op1_i     = a;
    op2_i     = b;
    rd_addr_i = rd;
    lat    = ref_lat(f3, a, b);
    e.rd   = rd;
    e.data = ref_op(f3, a, b);
    e.due  = cyc + lat;
    q.push_back(e);
    #1 hold_ok = hold_flag_o;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 1; k < lat; k++) begin
      #1 hold_ok &= hold_flag_o;
      @(negedge clk);
    end
    #1 hold_ok &= ~hold_flag_o;
    check("hold_window", {63'b0, hold_ok}, 64'h1);
    @(negedge clk);
  endtask

  task automatic start_raw(input logic [2:0] f3,
                           input logic [31:0] a,
                           input logic [31:0] b);
    @(negedge clk);
    start_i   = 1'b1;
    funct3_i  = f3;
    op1_i     = a;
    op2_i     = b;
    rd_addr_i = 5'd9;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] tbl [6];
    tbl = '{32'h0, 32'h1, 32'hFFFF_FFFF,
            32'h8000_0000, 32'h7FFF_FFFF, 32'h7};
    if ($urandom_range(0, 3) == 0) return tbl[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    rst_n     = 1'b0;
    start_i   = 1'b0;
    funct3_i  = '0;
    op1_i     = '0;
    op2_i     = '0;
    rd_addr_i = '0;
    flush_i   = 1'b0;
    #1;
    check("reset_outs",
          {rd_data_o, 27'b0, rd_addr_o},
          64'h0);
    check("reset_ctl",
          {61'b0, rd_wen_o, busy_o, hold_flag_o}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op(3'd5, 32'd100, 32'd7, 5'd7);
    run_op(3'd7, 32'd100, 32'd7, 5'd8);
    run_op(3'd5, 32'd5, 32'd0, 5'd10);
    run_op(3'd6, 32'd5, 32'd0, 5'd11);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);

    // Flush at T+10 of a divide: no writeback, idle at T+11.
    start_raw(3'd4, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("flush_idle", {63'b0, busy_o}, 64'h0);
    run_op(3'd0, 32'd12345, 32'd678, 5'd14);

    // Flush landing on the DONE cycle suppresses the strobe.
    start_raw(3'd5, 32'd100, 32'd7);
    repeat (XLEN + 1) @(negedge clk);
    flush_i = 1'b1;
    #1 check("flush_done_wen", {63'b0, rd_wen_o}, 64'h0);
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("flush_done_idle", {63'b0, busy_o}, 64'h0);

    // Reset at T+5 of a divide clears everything immediately.
    start_raw(3'd4, 32'hFFFF_FF00, 32'd5);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {rd_data_o, 27'b0, rd_addr_o}, 64'h0);
    check("midrst_ctl",
          {61'b0, rd_wen_o, busy_o, hold_flag_o}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd6, 32'hFFFF_FF00, 32'd7, 5'd15);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(),
             5'($urandom_range(1, 31)));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
